frame_swap_ctrl: RTL and testbench
==================================

# frame_swap_ctrl

Double-buffer sequencer between the Painter and the red/green/blue frame buffers in the draw unit. Forwards Painter pixel writes into the back buffer, waits for vertical blanking on a swap request, flips front/back, and can optionally fill the new back buffer with a background colour before releasing the Painter. It owns the write port of the frame buffers and the VGA read base offset.

## Interface
Parameters:
- PIXELS, 19200 — pixels per buffer (160×120)
- BUF_OFFSET, 19200 — base address of buffer 1; buffer 0 is based at 0
- ADDR_W, 16 — frame buffer address width

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high
- swap_req  in  1  Painter frame done; level, held until swap_ack
- swap_ack  out  1  one-cycle pulse; swap (and clear, if enabled) complete
- vblank  in  1  vertical blanking level, already synchronised to clk
- clear_en  in  1  fill new back buffer after swap; sampled with swap_req
- clear_color  in  3  fill colour {R,G,B}; sampled with swap_req
- p_we  in  1  Painter pixel write strobe
- p_addr  in  15  Painter pixel address, 0..PIXELS-1
- p_data  in  3  Painter pixel colour
- p_stall  out  1  Painter must not write while high
- fb_we  out  1  frame buffer write enable
- fb_addr  out  ADDR_W  frame buffer write address
- fb_data  out  3  frame buffer write colour
- rd_offset  out  ADDR_W  front buffer base for VGA reads (0 or BUF_OFFSET)
- busy  out  1  high in any state other than DRAW

## Operation
- State register front_sel: 0 → front base 0, back base BUF_OFFSET; 1 → front base BUF_OFFSET, back base 0. rd_offset = front base.
- States:
  - DRAW: p_stall=0. p_we is forwarded as fb_we=1, fb_addr=p_addr+back base, fb_data=p_data. swap_req=1 latches clear_en and clear_color, then moves to WAIT_VBL. A p_we in that same cycle is still forwarded.
  - WAIT_VBL: p_stall=1, fb_we=0. The first cycle with vblank=1 moves to SWAP. If vblank is already high on entry, the swap proceeds on the next cycle.
  - SWAP: single cycle. Toggles front_sel. Next state is CLEAR if the latched clear_en=1, else DRAW with swap_ack.
  - CLEAR: p_stall=1. Counter runs 0..PIXELS-1 and writes fb_addr = counter + new back base, fb_data = latched colour, one pixel per cycle. After the counter reaches PIXELS-1, the next state is DRAW with swap_ack.
- swap_ack pulses exactly once per accepted swap_req, on the first DRAW cycle after SWAP or CLEAR.
- A p_we asserted while p_stall=1 is a Painter protocol error. It is ignored, with no write and no state effect.
- Address arithmetic is unsigned ADDR_W bits. p_addr ≥ PIXELS is forwarded unchanged and is not checked.
- Reset (asynchronous, any state including mid-CLEAR): state=DRAW, front_sel=0, counter=0, latched clear fields=0. All outputs 0 except rd_offset=0 (back base BUF_OFFSET). An interrupted clear is abandoned.

## Timing
- fb_we, fb_addr and fb_data are registered. A forwarded p_we at cycle N appears at N+1.
- swap_req first seen high in DRAW at cycle 0 → WAIT_VBL at cycle 1.
- vblank sampled high at cycle k → SWAP at k+1 → rd_offset updates at k+2.
- Without clear: swap_ack=1 and p_stall=0 at k+2.
- With clear: fill writes are visible at k+3..k+2+PIXELS, exactly PIXELS contiguous fb_we cycles. swap_ack=1 and p_stall=0 at k+3+PIXELS.
- p_stall and busy are decoded from the state register (no input-to-output combinational path).
- swap_req still high in the cycle after swap_ack is treated as a new request.

## Structure
- Shared draw package: state enum (DRAW, WAIT_VBL, SWAP, CLEAR), the default PIXELS and BUF_OFFSET constants, and the colour width (3). DrawUnit and the Painter use the same constants.
- One natural sub-module: fill_counter, a PIXELS-bounded counter with start, done and count outputs. Everything else lives in a single FSM module.

## Test plan
- Reset, then p_we=1, p_addr=5, p_data=3'b101 → next cycle fb_we=1, fb_addr=19205, fb_data=3'b101; rd_offset=0.
- swap_req=1, clear_en=0 with vblank=0 for 10 cycles, then vblank=1 → p_stall=1 throughout the wait; rd_offset=19200 and swap_ack pulse 2 cycles after vblank; p_addr=5 then maps to fb_addr=5.
- Bench with PIXELS=8, BUF_OFFSET=8, clear_en=1, clear_color=3'b010, vblank held high → after the swap, exactly 8 writes to fb_addr 0..7 with data 3'b010; swap_ack one cycle after the last write; no writes at addresses 8..15.
- Two back-to-back swaps → rd_offset goes 0→19200→0; exactly 2 swap_ack pulses.
- Reset asserted mid-CLEAR at counter=3 → outputs 0 immediately (asynchronous); after release state is DRAW, rd_offset=0, no further fill writes.
- p_we held high during WAIT_VBL and CLEAR → no Painter-originated fb_we in those states.

Source files
------------

// File: rtl/frame_swap_ctrl_pkg.sv
// Shared draw-unit constants and types used by the Painter, DrawUnit
// and the frame buffer swap sequencer.
package frame_swap_ctrl_pkg;

    localparam int DEF_PIXELS     = 19200;
    localparam int DEF_BUF_OFFSET = 19200;
    localparam int DEF_ADDR_W     = 16;
    localparam int COLOR_W        = 3;
    localparam int PADDR_W        = 15;

    typedef logic [1:0] state_t;

    localparam state_t ST_DRAW     = 2'd0;
    localparam state_t ST_WAIT_VBL = 2'd1;
    localparam state_t ST_SWAP     = 2'd2;
    localparam state_t ST_CLEAR    = 2'd3;

    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        logic   en;
        color_t color;
    } clr_cfg_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_swap_ctrl_if.sv
// Painter-facing and frame-buffer-facing signals of the swap sequencer.
// master = Painter/VGA side, slave = sequencer.
interface frame_swap_ctrl_if #(
    parameter int ADDR_W = 16
);
    import frame_swap_ctrl_pkg::*;

    logic               swap_req;
    logic               swap_ack;
    logic               vblank;
    logic               clear_en;
    color_t             clear_color;
    logic               p_we;
    logic [PADDR_W-1:0] p_addr;
    color_t             p_data;
    logic               p_stall;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    color_t             fb_data;
    logic [ADDR_W-1:0]  rd_offset;
    logic               busy;

    modport master (
        output swap_req,
        output vblank,
        output clear_en,
        output clear_color,
        output p_we,
        output p_addr,
        output p_data,
        input  swap_ack,
        input  p_stall,
        input  fb_we,
        input  fb_addr,
        input  fb_data,
        input  rd_offset,
        input  busy
    );

    modport slave (
        input  swap_req,
        input  vblank,
        input  clear_en,
        input  clear_color,
        input  p_we,
        input  p_addr,
        input  p_data,
        output swap_ack,
        output p_stall,
        output fb_we,
        output fb_addr,
        output fb_data,
        output rd_offset,
        output busy
    );

endinterface

// File: rtl/frame_swap_ctrl_fill_counter.sv
// PIXELS-bounded fill counter: start arms it at 0, it steps once per cycle
// and raises done for one cycle after the last index has been issued.
module frame_swap_ctrl_fill_counter
    import frame_swap_ctrl_pkg::*;
#(
    parameter int PIXELS = DEF_PIXELS,
    parameter int CNT_W  = cnt_width(PIXELS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic             o_active,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS - 1);

    logic             r_active;
    logic             r_done;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else if (r_active) begin
            if (r_count == LAST) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
                r_count  <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_active = r_active;
    assign o_done   = r_done;
    assign o_count  = r_count;

endmodule

// File: rtl/frame_swap_ctrl.sv
// Double-buffer sequencer: forwards Painter writes to the back buffer,
// flips buffers in vertical blanking and optionally clears the new back.
module frame_swap_ctrl
    import frame_swap_ctrl_pkg::*;
#(
    parameter int PIXELS     = DEF_PIXELS,
    parameter int BUF_OFFSET = DEF_BUF_OFFSET,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    frame_swap_ctrl_if.slave   bus
);

    localparam int               CNT_W = cnt_width(PIXELS);
    localparam logic [ADDR_W-1:0] OFFS = ADDR_W'(BUF_OFFSET);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_front_sel;
    clr_cfg_t          r_clr;
    logic              r_fb_we;
    logic [ADDR_W-1:0] r_fb_addr;
    color_t            r_fb_data;
    logic              r_ack;

    logic              w_in_draw;
    logic              w_in_swap;
    logic              w_in_clear;
    logic [ADDR_W-1:0] w_back_base;
    logic [ADDR_W-1:0] w_front_base;
    logic              w_fill_start;
    logic              w_fill_active;
    logic              w_fill_done;
    logic [CNT_W-1:0]  w_fill_cnt;
    logic              w_paint_we;
    logic              w_fill_we;

    assign w_in_draw  = (r_state == ST_DRAW);
    assign w_in_swap  = (r_state == ST_SWAP);
    assign w_in_clear = (r_state == ST_CLEAR);

    assign w_back_base  = r_front_sel ? '0 : OFFS;
    assign w_front_base = r_front_sel ? OFFS : '0;

    assign w_fill_start = w_in_swap & r_clr.en;
    assign w_paint_we   = w_in_draw & bus.p_we;
    assign w_fill_we    = w_in_clear & w_fill_active;

    frame_swap_ctrl_fill_counter #(
        .PIXELS (PIXELS),
        .CNT_W  (CNT_W)
    ) u_fill (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_fill_start),
        .o_active (w_fill_active),
        .o_done   (w_fill_done),
        .o_count  (w_fill_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_DRAW: begin
                if (bus.swap_req) w_state_nxt = ST_WAIT_VBL;
            end
            ST_WAIT_VBL: begin
                if (bus.vblank) w_state_nxt = ST_SWAP;
            end
            ST_SWAP: begin
                w_state_nxt = r_clr.en ? ST_CLEAR : ST_DRAW;
            end
            ST_CLEAR: begin
                if (w_fill_done) w_state_nxt = ST_DRAW;
            end
            default: w_state_nxt = ST_DRAW;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_DRAW;
            r_front_sel <= 1'b0;
            r_clr       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_swap) r_front_sel <= ~r_front_sel;
            if (w_in_draw && bus.swap_req) begin
                r_clr.en    <= bus.clear_en;
                r_clr.color <= bus.clear_color;
            end
        end
    end

    // Address/data only move on a real write so the bus stays quiet otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
            r_ack     <= 1'b0;
        end else begin
            r_fb_we <= w_paint_we | w_fill_we;
            if (w_fill_we) begin
                r_fb_addr <= ADDR_W'(w_fill_cnt) + w_back_base;
                r_fb_data <= r_clr.color;
            end else if (w_paint_we) begin
                r_fb_addr <= ADDR_W'(bus.p_addr) + w_back_base;
                r_fb_data <= bus.p_data;
            end
            r_ack <= (w_in_swap & ~r_clr.en) | (w_in_clear & w_fill_done);
        end
    end

    assign bus.fb_we     = r_fb_we;
    assign bus.fb_addr   = r_fb_addr;
    assign bus.fb_data   = r_fb_data;
    assign bus.swap_ack  = r_ack;
    assign bus.p_stall   = ~w_in_draw;
    assign bus.busy      = ~w_in_draw;
    assign bus.rd_offset = w_front_base;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Scenario bench for frame_swap_ctrl: a full-size instance and a tiny
// 8-pixel instance, checked against expected values derived from the rules.
module tb_frame_swap_ctrl;
    import frame_swap_ctrl_pkg::*;

    localparam int BP = 19200;
    localparam int BO = 19200;
    localparam int SP = 8;
    localparam int SO = 8;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    frame_swap_ctrl_if #(.ADDR_W(AW)) bif ();
    frame_swap_ctrl_if #(.ADDR_W(AW)) sif ();

    frame_swap_ctrl #(
        .PIXELS     (BP),
        .BUF_OFFSET (BO),
        .ADDR_W     (AW)
    ) u_big (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    frame_swap_ctrl #(
        .PIXELS     (SP),
        .BUF_OFFSET (SO),
        .ADDR_W     (AW)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    int big_swaps   = 0;
    int small_swaps = 0;

    // Even swap count: front at 0, back at offset; odd count: reversed.
    function automatic logic [AW-1:0] back_of(input int swaps, input int off);
        return (swaps % 2 == 0) ? AW'(off) : AW'(0);
    endfunction

    function automatic logic [AW-1:0] front_of(input int swaps, input int off);
        return (swaps % 2 == 0) ? AW'(0) : AW'(off);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bif.swap_req = 0; bif.vblank = 0; bif.clear_en = 0;
        bif.clear_color = 0; bif.p_we = 0; bif.p_addr = 0; bif.p_data = 0;
        sif.swap_req = 0; sif.vblank = 0; sif.clear_en = 0;
        sif.clear_color = 0; sif.p_we = 0; sif.p_addr = 0; sif.p_data = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({bif.fb_we, bif.fb_addr, bif.fb_data, bif.swap_ack, bif.p_stall,
             bif.busy, bif.rd_offset} !== '0)
            $display("FAIL reset_big: got we=%b addr=%0d ack=%b stall=%b busy=%b rd=%0d want all 0",
                     bif.fb_we, bif.fb_addr, bif.swap_ack, bif.p_stall, bif.busy, bif.rd_offset);
        else n_pass++;
        n_total++;
        if ({sif.fb_we, sif.fb_addr, sif.fb_data, sif.swap_ack, sif.p_stall,
             sif.busy, sif.rd_offset} !== '0)
            $display("FAIL reset_small: got we=%b addr=%0d ack=%b stall=%b busy=%b rd=%0d want all 0",
                     sif.fb_we, sif.fb_addr, sif.swap_ack, sif.p_stall, sif.busy, sif.rd_offset);
        else n_pass++;
        reset = 1'b0;
        big_swaps = 0;
        small_swaps = 0;
        tick();
        n_total++;
        if ({bif.fb_we, bif.swap_ack, bif.p_stall, bif.busy, bif.rd_offset} !== '0)
            $display("FAIL reset_release: got we=%b ack=%b stall=%b busy=%b rd=%0d want all 0",
                     bif.fb_we, bif.swap_ack, bif.p_stall, bif.busy, bif.rd_offset);
        else n_pass++;
    endtask

    task automatic test_forward(input int n);
        int a;
        logic [2:0] d;
        logic [AW-1:0] ea;
        for (int i = 0; i < n; i++) begin
            a = (i == 0) ? 5 : (i == 1) ? 32767 : $urandom_range(0, BP - 1);
            d = (i == 0) ? 3'b101 : 3'($urandom_range(0, 7));
            ea = AW'(a + ((big_swaps % 2 == 0) ? BO : 0));
            bif.p_we = 1; bif.p_addr = 15'(a); bif.p_data = d;
            tick();
            n_total++;
            if (bif.fb_we !== 1'b1 || bif.fb_addr !== ea || bif.fb_data !== d)
                $display("FAIL forward: got we=%b addr=%0d data=%b want we=1 addr=%0d data=%b",
                         bif.fb_we, bif.fb_addr, bif.fb_data, ea, d);
            else n_pass++;
            n_total++;
            if (bif.rd_offset !== front_of(big_swaps, BO))
                $display("FAIL forward_rd: got %0d want %0d",
                         bif.rd_offset, front_of(big_swaps, BO));
            else n_pass++;
            bif.p_we = 0;
            tick();
            n_total++;
            if (bif.fb_we !== 1'b0)
                $display("FAIL forward_idle: got we=%b want 0", bif.fb_we);
            else n_pass++;
        end
    endtask

    task automatic test_swap_noclear(input int w);
        logic [AW-1:0] ea;
        bif.swap_req = 1; bif.clear_en = 0; bif.vblank = 0;
        tick();
        bif.p_we = 1; bif.p_addr = 15'd77; bif.p_data = 3'b001;
        for (int i = 0; i < w; i++) begin
            n_total++;
            if ({bif.p_stall, bif.busy, bif.fb_we, bif.swap_ack} !== 4'b1100)
                $display("FAIL wait_vbl: got stall=%b busy=%b we=%b ack=%b want 1 1 0 0",
                         bif.p_stall, bif.busy, bif.fb_we, bif.swap_ack);
            else n_pass++;
            tick();
        end
        bif.vblank = 1;
        tick();
        bif.vblank = 0;
        n_total++;
        if ({bif.p_stall, bif.swap_ack, bif.fb_we} !== 3'b100 ||
            bif.rd_offset !== front_of(big_swaps, BO))
            $display("FAIL swap_cycle: got stall=%b ack=%b we=%b rd=%0d want 1 0 0 rd=%0d",
                     bif.p_stall, bif.swap_ack, bif.fb_we, bif.rd_offset,
                     front_of(big_swaps, BO));
        else n_pass++;
        tick();
        big_swaps++;
        n_total++;
        if ({bif.p_stall, bif.swap_ack, bif.fb_we} !== 3'b010 ||
            bif.rd_offset !== front_of(big_swaps, BO))
            $display("FAIL swap_ack: got stall=%b ack=%b we=%b rd=%0d want 0 1 0 rd=%0d",
                     bif.p_stall, bif.swap_ack, bif.fb_we, bif.rd_offset,
                     front_of(big_swaps, BO));
        else n_pass++;
        bif.swap_req = 0; bif.p_we = 0;
        tick();
        n_total++;
        if ({bif.swap_ack, bif.fb_we, bif.busy} !== 3'b000)
            $display("FAIL ack_single: got ack=%b we=%b busy=%b want 0 0 0",
                     bif.swap_ack, bif.fb_we, bif.busy);
        else n_pass++;
        ea = AW'(5 + ((big_swaps % 2 == 0) ? BO : 0));
        bif.p_we = 1; bif.p_addr = 15'd5; bif.p_data = 3'b110;
        tick();
        bif.p_we = 0;
        n_total++;
        if (bif.fb_we !== 1'b1 || bif.fb_addr !== ea || bif.fb_data !== 3'b110)
            $display("FAIL post_swap_map: got we=%b addr=%0d data=%b want we=1 addr=%0d data=110",
                     bif.fb_we, bif.fb_addr, bif.fb_data, ea);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int first = -1;
        bif.swap_req = 1; bif.vblank = 1; bif.clear_en = 0;
        for (int c = 1; c <= 30 && acks < 2; c++) begin
            tick();
            if (bif.swap_ack === 1'b1) begin
                acks++;
                big_swaps++;
                n_total++;
                if (bif.rd_offset !== front_of(big_swaps, BO))
                    $display("FAIL b2b_rd: got %0d want %0d",
                             bif.rd_offset, front_of(big_swaps, BO));
                else n_pass++;
                if (acks == 1) begin
                    first = c;
                    n_total++;
                    if (c !== 3)
                        $display("FAIL b2b_first_ack: got cycle %0d want 3", c);
                    else n_pass++;
                end else begin
                    n_total++;
                    if (c - first !== 3)
                        $display("FAIL b2b_gap: got %0d want 3", c - first);
                    else n_pass++;
                    bif.swap_req = 0; bif.vblank = 0;
                end
            end
        end
        bif.swap_req = 0; bif.vblank = 0;
        repeat (6) begin
            tick();
            if (bif.swap_ack === 1'b1) acks++;
        end
        n_total++;
        if (acks !== 2)
            $display("FAIL b2b_count: got %0d acks want 2", acks);
        else n_pass++;
        n_total++;
        if (bif.rd_offset !== AW'(0) || bif.busy !== 1'b0)
            $display("FAIL b2b_final: got rd=%0d busy=%b want rd=0 busy=0",
                     bif.rd_offset, bif.busy);
        else n_pass++;
    endtask

    task automatic test_clear(input int iter);
        logic [2:0] color;
        logic [AW-1:0] nb;
        logic [AW-1:0] ea;
        int writes = 0;
        int first_w = -1;
        int last_w = -1;
        int ack_c = -1;
        color = (iter == 0) ? 3'b010 : 3'($urandom_range(0, 7));
        nb = back_of(small_swaps + 1, SO);
        sif.swap_req = 1; sif.clear_en = 1; sif.clear_color = color; sif.vblank = 1;
        for (int c = 1; c <= 60 && ack_c < 0; c++) begin
            tick();
            if (c == 1) begin
                sif.clear_en = 0; sif.clear_color = ~color;
                sif.p_we = 1;
                sif.p_addr = 15'(100 + $urandom_range(0, 50));
                sif.p_data = ~color;
            end
            if (sif.fb_we === 1'b1) begin
                ea = AW'(nb + AW'(writes));
                n_total++;
                if (sif.fb_addr !== ea || sif.fb_data !== color)
                    $display("FAIL clear_write: got addr=%0d data=%b want addr=%0d data=%b",
                             sif.fb_addr, sif.fb_data, ea, color);
                else n_pass++;
                if (first_w < 0) first_w = c;
                last_w = c;
                writes++;
            end
            if (sif.swap_ack === 1'b1) begin
                ack_c = c;
                n_total++;
                if (sif.p_stall !== 1'b0)
                    $display("FAIL clear_ack_stall: got %b want 0", sif.p_stall);
                else n_pass++;
                sif.swap_req = 0; sif.p_we = 0; sif.vblank = 0;
            end
        end
        sif.swap_req = 0; sif.p_we = 0; sif.vblank = 0;
        small_swaps++;
        n_total++;
        if (writes !== SP || first_w !== 4 || last_w !== first_w + SP - 1)
            $display("FAIL clear_span: got n=%0d first=%0d last=%0d want n=%0d first=4 last=%0d",
                     writes, first_w, last_w, SP, 3 + SP);
        else n_pass++;
        n_total++;
        if (ack_c !== last_w + 1)
            $display("FAIL clear_ack_time: got cycle %0d want %0d", ack_c, last_w + 1);
        else n_pass++;
        n_total++;
        if (sif.rd_offset !== front_of(small_swaps, SO))
            $display("FAIL clear_rd: got %0d want %0d",
                     sif.rd_offset, front_of(small_swaps, SO));
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int writes = 0;
        sif.swap_req = 1; sif.clear_en = 1;
        sif.clear_color = 3'($urandom_range(1, 7)); sif.vblank = 1;
        for (int c = 1; c <= 30 && writes < 3; c++) begin
            tick();
            if (c == 1) sif.clear_en = 0;
            if (sif.fb_we === 1'b1) writes++;
        end
        n_total++;
        if (writes !== 3)
            $display("FAIL midclr_reach: got %0d writes want 3", writes);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if ({sif.fb_we, sif.fb_addr, sif.fb_data, sif.swap_ack, sif.p_stall,
             sif.busy, sif.rd_offset} !== '0)
            $display("FAIL midclr_async: got we=%b addr=%0d ack=%b stall=%b busy=%b rd=%0d want all 0",
                     sif.fb_we, sif.fb_addr, sif.swap_ack, sif.p_stall, sif.busy, sif.rd_offset);
        else n_pass++;
        idle_all();
        tick();
        reset = 1'b0;
        small_swaps = 0;
        big_swaps = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_total++;
            if ({sif.fb_we, sif.swap_ack, sif.busy, sif.p_stall} !== 4'b0000 ||
                sif.rd_offset !== AW'(0))
                $display("FAIL midclr_after: got we=%b ack=%b busy=%b stall=%b rd=%0d want 0 0 0 0 rd=0",
                         sif.fb_we, sif.swap_ack, sif.busy, sif.p_stall, sif.rd_offset);
            else n_pass++;
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_forward(8);
        test_swap_noclear(10);
        test_swap_noclear($urandom_range(2, 12));
        test_forward(4);
        test_reset();
        test_back_to_back();
        test_clear(0);
        test_clear(1);
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
